gcd_binary: RTL

Parametrised successor to the 6-bit subtractive GCD unit. It computes gcd(A, B) of two unsigned WIDTH-bit operands using the binary (Stein) algorithm, one reduction step per clock. It uses a ready/valid operand handshake and a valid/ack result handshake, and reports the number of iteration cycles. It sits on the same operand/result bus as the existing GCD block and can replace it in designs that need wider operands or bounded latency.

---
 rtl/gcd_pkg.sv | 16 +
 rtl/gcd_binary_step.sv | 51 +++++
 rtl/gcd_binary.sv | 124 ++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD units: controller state encodings and the
// cycle-counter width helper.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } gcd_state_e;

    // Binary GCD finishes within 2*width+1 steps; the counter must hold that.
    function automatic int gcd_cw(input int width);
        return $clog2(2 * width + 2);
    endfunction

endpackage

// File: rtl/gcd_binary_step.sv
// One reduction step of the binary (Stein) GCD algorithm. The rules are
// evaluated in priority order and exactly one of them applies.
module gcd_binary_step #(
    parameter int WIDTH = 16,
    parameter int KW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next,
    output logic             k_inc,
    output logic             terminal,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] diff_ba;

    assign diff_ab = a - b;
    assign diff_ba = b - a;

    always_comb begin
        a_next   = a;
        b_next   = b;
        k_inc    = 1'b0;
        terminal = 1'b0;
        result   = '0;
        if (a == '0) begin
            terminal = 1'b1;
            result   = b << k;
        end else if (b == '0) begin
            terminal = 1'b1;
            result   = a << k;
        end else if (!a[0] && !b[0]) begin
            a_next = a >> 1;
            b_next = b >> 1;
            k_inc  = 1'b1;
        end else if (!a[0]) begin
            a_next = a >> 1;
        end else if (!b[0]) begin
            b_next = b >> 1;
        end else if (a >= b) begin
            // Both odd: the difference is even, so the halving is exact.
            a_next = diff_ab >> 1;
        end else begin
            b_next = diff_ba >> 1;
        end
    end

endmodule

// File: rtl/gcd_binary.sv
// Binary GCD engine: ready/valid operand accept, one reduction per clock,
// result and iteration count held until acknowledged.
module gcd_binary
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CW    = gcd_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic             ack,
    output logic             gcd_valid,
    output logic [WIDTH-1:0] gcd,
    output logic [CW-1:0]    cycles
);

    localparam int KW = $clog2(WIDTH);

    gcd_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [CW-1:0]    cycles_q, cycles_d;

    logic [WIDTH-1:0] step_a;
    logic [WIDTH-1:0] step_b;
    logic             step_k_inc;
    logic             step_terminal;
    logic [WIDTH-1:0] step_result;

    gcd_binary_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .a        (a_q),
        .b        (b_q),
        .k        (k_q),
        .a_next   (step_a),
        .b_next   (step_b),
        .k_inc    (step_k_inc),
        .terminal (step_terminal),
        .result   (step_result)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        gcd_d    = gcd_q;
        cycles_d = cycles_q;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    a_d     = A_in;
                    b_d     = B_in;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                a_d   = step_a;
                b_d   = step_b;
                if (step_k_inc) begin
                    k_d = k_q + KW'(1);
                end
                if (step_terminal) begin
                    gcd_d    = step_result;
                    cycles_d = cnt_q + CW'(1);
                    state_d  = DONE;
                end
            end
            DONE: begin
                // Result registers are cleared on leaving DONE so the
                // outputs read zero whenever gcd_valid is low.
                if (ack) begin
                    gcd_d    = '0;
                    cycles_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                gcd_d    = '0;
                cycles_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            cnt_q    <= '0;
            gcd_q    <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            gcd_q    <= gcd_d;
            cycles_q <= cycles_d;
        end
    end

    assign op_ready  = (state_q == IDLE);
    assign gcd_valid = (state_q == DONE);
    assign gcd       = gcd_q;
    assign cycles    = cycles_q;

endmodule
